// File: rtl/ro_puf_pair_meas.sv
// Ring-oscillator PUF pair measurement: enables a challenge-selected pair, settles,
// counts synchronised rising edges of both over a fixed window and compares them.
module ro_puf_pair_meas #(
   parameter int unsigned NUM_RO     = 8,
   parameter int unsigned SEL_W      = $clog2(NUM_RO),
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned SETTLE_CYC = 64,
   parameter int unsigned WINDOW_CYC = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SEL_W-1:0]  sel_a,
   input  logic [SEL_W-1:0]  sel_b,
   input  logic [NUM_RO-1:0] ro_in,
   output logic [NUM_RO-1:0] ro_en,
   output logic              busy,
   output logic              done,
   output logic              resp,
   output logic              tie,
   output logic              err,
   output logic              sat,
   output logic [CNT_W-1:0]  cnt_a,
   output logic [CNT_W-1:0]  cnt_b
);

   localparam int unsigned MAX_CYC = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
   localparam int unsigned CYC_W   = $clog2(MAX_CYC + 1);
   localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
   localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_EVAL,
      S_DONE
   } state_t;

   state_t             state, state_n;
   logic [NUM_RO-1:0]  sync1, sync2, hist, rise;
   logic [SEL_W-1:0]   sa_q, sb_q, sa_n, sb_n;
   logic               bad_q, bad_n;
   logic [CYC_W-1:0]   cyc_q, cyc_n;
   logic [CNT_W-1:0]   ea_q, eb_q, ea_n, eb_n;
   logic [NUM_RO-1:0]  en_n;

   // Two-flop synchroniser plus history flop, free-running in every state
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
      end else begin
         sync1 <= ro_in;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign rise = sync2 & ~hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         sa_q  <= '0;
         sb_q  <= '0;
         bad_q <= 1'b0;
         cyc_q <= '0;
         ea_q  <= '0;
         eb_q  <= '0;
      end else begin
         state <= state_n;
         sa_q  <= sa_n;
         sb_q  <= sb_n;
         bad_q <= bad_n;
         cyc_q <= cyc_n;
         ea_q  <= ea_n;
         eb_q  <= eb_n;
      end
   end

   always_comb begin
      state_n = state;
      sa_n    = sa_q;
      sb_n    = sb_q;
      bad_n   = bad_q;
      cyc_n   = cyc_q;
      ea_n    = ea_q;
      eb_n    = eb_q;
      en_n    = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               sa_n    = sel_a;
               sb_n    = sel_b;
               bad_n   = (sel_a == sel_b) || (32'(sel_a) >= NUM_RO) || (32'(sel_b) >= NUM_RO);
               cyc_n   = '0;
               ea_n    = '0;
               eb_n    = '0;
               state_n = bad_n ? S_EVAL : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cyc_q == SETTLE_LAST) begin
               cyc_n   = '0;
               state_n = S_MEASURE;
            end else begin
               cyc_n = cyc_q + CYC_W'(1);
            end
         end
         S_MEASURE: begin
            // Counters stick at all-ones; saturation is read off at evaluation
            if (rise[sa_q] && (ea_q != CNT_MAX)) ea_n = ea_q + CNT_W'(1);
            if (rise[sb_q] && (eb_q != CNT_MAX)) eb_n = eb_q + CNT_W'(1);
            if (cyc_q == WINDOW_LAST) begin
               state_n = S_EVAL;
            end else begin
               cyc_n = cyc_q + CYC_W'(1);
            end
         end
         S_EVAL:  state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if ((state_n == S_SETTLE) || (state_n == S_MEASURE)) begin
         for (int i = 0; i < int'(NUM_RO); i++) begin
            en_n[i] = (SEL_W'(i) == sa_n) || (SEL_W'(i) == sb_n);
         end
      end
   end

   // Registered outputs; results captured on the edge entering DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         ro_en <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         resp  <= 1'b0;
         tie   <= 1'b0;
         err   <= 1'b0;
         sat   <= 1'b0;
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         ro_en <= en_n;
         busy  <= (state_n != S_IDLE);
         done  <= (state_n == S_DONE);
         if (state == S_EVAL) begin
            err   <= bad_q;
            cnt_a <= bad_q ? '0 : ea_q;
            cnt_b <= bad_q ? '0 : eb_q;
            resp  <= !bad_q && (ea_q > eb_q);
            tie   <= !bad_q && (ea_q == eb_q);
            sat   <= !bad_q && ((ea_q == CNT_MAX) || (eb_q == CNT_MAX));
         end
      end
   end

endmodule

// File: doc/ro_puf_pair_meas.md
Name: ro_puf_pair_meas

Overview:
- Parametrised ring-oscillator PUF measurement controller.
- Enables a challenge-selected pair out of NUM_RO divided ring-oscillator outputs, lets them settle, then counts their rising edges over a fixed window in the system clock domain.
- Produces one response bit (A faster than B), plus raw counts and a tie flag.
- Sits between the ring-oscillator bank (each ring followed by its /N toggle divider) and the PUF response collector. Replaces per-oscillator free-running edge counters.

Parameters:
- NUM_RO, 8: number of oscillator channels; must be ≥ 2.
- SEL_W, $clog2(NUM_RO): width of the channel select fields.
- CNT_W, 16: edge-counter width. Counters saturate at 2^CNT_W-1.
- SETTLE_CYC, 64: clk cycles the ring oscillators run before counting starts; must be ≥ 1.
- WINDOW_CYC, 4096: clk cycles in the counting window; must be ≥ 1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request a measurement; sampled only in IDLE.
- sel_a, in, SEL_W: challenge, channel A index.
- sel_b, in, SEL_W: challenge, channel B index.
- ro_in, in, NUM_RO: divided oscillator outputs. Asynchronous to clk; toggle rate must be < clk/4.
- ro_en, out, NUM_RO: per-channel oscillator enable.
- busy, out, 1: high from start acceptance until done.
- done, out, 1: one-cycle pulse marking valid results.
- resp, out, 1: 1 when cnt_a > cnt_b.
- tie, out, 1: 1 when cnt_a == cnt_b.
- err, out, 1: 1 for an invalid challenge.
- sat, out, 1: 1 when either counter saturated.
- cnt_a, out, CNT_W: final edge count of channel A.
- cnt_b, out, CNT_W: final edge count of channel B.

Behaviour:
- Reset: all outputs 0, ro_en all 0, state IDLE, counters and synchronisers 0. rst mid-measurement aborts immediately (ro_en drops the next edge, no done).
- Input conditioning: every ro_in bit passes through a 2-flop synchroniser plus a 1-flop history register, running in all states. A rising edge is sync=1 && hist=0.
- State IDLE:
  - On start=1, latch sel_a/sel_b and set busy=1.
  - If sel_a==sel_b, or either index ≥ NUM_RO, go to DONE with err=1, cnt_a=cnt_b=0, resp=0, tie=0, sat=0.
  - Otherwise go to SETTLE. Clear the window counter and both edge counters.
- State SETTLE:
  - ro_en has exactly bits sel_a and sel_b set.
  - Stay for SETTLE_CYC cycles; edges are ignored.
  - Then go to MEASURE.
- State MEASURE:
  - ro_en unchanged.
  - Stay for exactly WINDOW_CYC cycles. In each cycle, a detected rising edge on channel sel_a (sel_b) increments cnt_a (cnt_b) by 1.
  - A counter at all-ones holds its value and sets its saturation flag.
  - After the last cycle go to DONE.
- State DONE:
  - Lasts one cycle. done=1, ro_en all 0.
  - cnt_a, cnt_b, resp, tie, err and sat are registered on entry to DONE and hold until the next start is accepted.
  - resp = (cnt_a > cnt_b); tie = (cnt_a == cnt_b). Unsigned compare of the saturated values.
  - Then go to IDLE; busy=0 from the following cycle.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge E0+SETTLE_CYC+WINDOW_CYC+1. An invalid challenge gives done=1 in the cycle after E0+1.
- start while busy is ignored. Challenge changes while busy are ignored.
- start high in the DONE cycle is ignored. Only a start sampled in IDLE is accepted, so back-to-back requests are one cycle apart at minimum.
- Results outputs are 0 until the first done.

Test Plan:
- Frequency order: NUM_RO=8, SETTLE_CYC=16, WINDOW_CYC=1000. ro_in[2] toggles every 5 clk (rising edge every 10), ro_in[5] toggles every 7 clk; sel_a=2, sel_b=5, pulse start. Required: cnt_a ∈ {99,100,101}, cnt_b ∈ {70,71,72}, resp=1, tie=0, err=0, done exactly 1018 cycles after start. ro_en=8'b0010_0100 during SETTLE/MEASURE and 0 in IDLE.
- Swap: sel_a=5, sel_b=2 with the same stimulus → resp=0, tie=0, counts swapped.
- Tie: the same waveform drives ro_in[1] and ro_in[3]; sel_a=1, sel_b=3 → cnt_a==cnt_b, tie=1, resp=0.
- Invalid challenge: sel_a=sel_b=4 → done two cycles after start, err=1, counts 0, ro_en never asserted. Repeat with sel_b=7 under NUM_RO=6 → err=1.
- Saturation: CNT_W=4; both channels toggle every 3 clk, window 1000 → cnt_a=cnt_b=15, sat=1, tie=1, resp=0.
- Robustness:
  - start re-pulsed and sel changed mid-MEASURE → no effect on the result.
  - rst asserted at MEASURE cycle 500 → next cycle all outputs 0, no done pulse.
  - A fresh start afterwards completes normally.
